// File: rtl/gsm_cmd_sequencer_if.sv
// Signal bundle between the mole/input logic, the game state manager and the
// command sequencer. The sequencer side is the master; the manager side is the slave.
interface gsm_cmd_sequencer_if;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       start_btn;
  logic       pause_btn;
  logic [2:0] gs_state;
  logic [1:0] gs_stage;
  logic [1:0] gs_lives;
  logic [6:0] gs_timer;
  logic       gs_timer_running;
  logic       gs_done;
  logic [3:0] flag;
  logic       trig;
  logic       busy;
  logic       err;

  modport master (
    input  hit_pulse, miss_pulse, start_btn, pause_btn,
    input  gs_state, gs_stage, gs_lives, gs_timer, gs_timer_running, gs_done,
    output flag, trig, busy, err
  );

  modport slave (
    output hit_pulse, miss_pulse, start_btn, pause_btn,
    output gs_state, gs_stage, gs_lives, gs_timer, gs_timer_running, gs_done,
    input  flag, trig, busy, err
  );
endinterface

// File: rtl/gsm_cmd_sequencer.sv
// Turns mole events, button presses and observed game status into one flag/trig
// command at a time and completes the trig/done handshake with the game state manager.
module gsm_cmd_sequencer #(
  parameter int GAP_CYCLES = 3,
  parameter int TIMEOUT    = 16,
  parameter int PEND_W     = 4,
  parameter int LAST_STAGE = 3
) (
  input  logic                 clk_1mhz,
  input  logic                 rst,
  gsm_cmd_sequencer_if.master  bus
);

  localparam logic [2:0] ST_READY   = 3'b001;
  localparam logic [2:0] ST_PLAYING = 3'b010;
  localparam logic [2:0] ST_OVER    = 3'b011;
  localparam logic [2:0] ST_SCLEAR  = 3'b100;
  localparam logic [2:0] ST_GCLEAR  = 3'b101;

  localparam logic [3:0] CMD_HIT       = 4'b0001;
  localparam logic [3:0] CMD_MISS      = 4'b0010;
  localparam logic [3:0] CMD_PAUSE     = 4'b0100;
  localparam logic [3:0] CMD_RESUME    = 4'b0101;
  localparam logic [3:0] CMD_TO_READY  = 4'b1000;
  localparam logic [3:0] CMD_TO_PLAY   = 4'b1010;
  localparam logic [3:0] CMD_SCLEAR    = 4'b1100;
  localparam logic [3:0] CMD_GAMEOVER  = 4'b1101;
  localparam logic [3:0] CMD_GCLEAR    = 4'b1110;
  localparam logic [3:0] CMD_RESTART   = 4'b1111;

  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} fsm_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_HIT, SRC_MISS, SRC_PAUSE} src_t;

  fsm_t              state_reg;
  src_t              src_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic [3:0]        flag_reg;
  logic              trig_reg;
  logic              busy_reg;
  logic              err_reg;
  logic              pause_req_reg;

  logic              playing;
  logic              capture_en;
  logic              consume;
  logic [1:0]        pend_inc;
  logic [1:0]        pend_dec;
  logic [1:0]        pend_nz;
  logic              pause_consume;

  logic              cmd_valid;
  logic [3:0]        cmd_flag;
  src_t              cmd_src;

  assign playing       = (bus.gs_state == ST_PLAYING);
  assign capture_en    = playing && bus.gs_timer_running;
  assign consume       = (state_reg == ISSUE) && bus.gs_done;
  assign pend_inc      = {bus.miss_pulse, bus.hit_pulse} & {2{capture_en}};
  assign pend_dec      = {consume && (src_reg == SRC_MISS), consume && (src_reg == SRC_HIT)};
  assign pause_consume = consume && (src_reg == SRC_PAUSE);

  // Index 0 counts hits, index 1 counts misses; both saturate and flush outside play.
  for (genvar gi = 0; gi < 2; gi++) begin : g_pend
    logic [PEND_W-1:0] cnt_reg;

    always_ff @(posedge clk_1mhz) begin
      if (rst || !playing) begin
        cnt_reg <= '0;
      end else if (pend_inc[gi] && !pend_dec[gi]) begin
        if (cnt_reg != {PEND_W{1'b1}}) cnt_reg <= cnt_reg + 1'b1;
      end else if (!pend_inc[gi] && pend_dec[gi]) begin
        if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
      end
    end

    assign pend_nz[gi] = (cnt_reg != '0);
  end

  // A fresh press wins over consumption of an earlier one.
  always_ff @(posedge clk_1mhz) begin
    if (rst || !playing) begin
      pause_req_reg <= 1'b0;
    end else if (bus.pause_btn) begin
      pause_req_reg <= 1'b1;
    end else if (pause_consume) begin
      pause_req_reg <= 1'b0;
    end
  end

  always_comb begin
    cmd_valid = 1'b0;
    cmd_flag  = 4'b0000;
    cmd_src   = SRC_NONE;
    case (bus.gs_state)
      ST_READY: begin
        if (bus.gs_timer == '0) begin
          cmd_valid = 1'b1;
          cmd_flag  = CMD_TO_PLAY;
        end else if (!bus.gs_timer_running) begin
          cmd_valid = 1'b1;
          cmd_flag  = CMD_RESUME;
        end
      end
      ST_PLAYING: begin
        if (bus.gs_lives == '0) begin
          cmd_valid = 1'b1;
          cmd_flag  = CMD_GAMEOVER;
        end else if (bus.gs_timer == '0) begin
          cmd_valid = 1'b1;
          cmd_flag  = (bus.gs_stage == 2'(LAST_STAGE)) ? CMD_GCLEAR : CMD_SCLEAR;
        end else if (pause_req_reg) begin
          cmd_valid = 1'b1;
          cmd_flag  = bus.gs_timer_running ? CMD_PAUSE : CMD_RESUME;
          cmd_src   = SRC_PAUSE;
        end else if (pend_nz[1]) begin
          cmd_valid = 1'b1;
          cmd_flag  = CMD_MISS;
          cmd_src   = SRC_MISS;
        end else if (pend_nz[0]) begin
          cmd_valid = 1'b1;
          cmd_flag  = CMD_HIT;
          cmd_src   = SRC_HIT;
        end
      end
      ST_SCLEAR: begin
        if (bus.start_btn) begin
          cmd_valid = 1'b1;
          cmd_flag  = CMD_TO_READY;
        end
      end
      ST_OVER, ST_GCLEAR: begin
        if (bus.start_btn) begin
          cmd_valid = 1'b1;
          cmd_flag  = CMD_RESTART;
        end
      end
      default: ;
    endcase
  end

  // A timed-out command keeps its source event pending, so it is reissued after GAP.
  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      state_reg   <= IDLE;
      src_reg     <= SRC_NONE;
      to_cnt_reg  <= '0;
      gap_cnt_reg <= '0;
      flag_reg    <= 4'b0000;
      trig_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            state_reg  <= ISSUE;
            flag_reg   <= cmd_flag;
            src_reg    <= cmd_src;
            trig_reg   <= 1'b1;
            busy_reg   <= 1'b1;
            to_cnt_reg <= '0;
          end
        end
        ISSUE: begin
          if (bus.gs_done) begin
            state_reg   <= GAP;
            trig_reg    <= 1'b0;
            gap_cnt_reg <= '0;
          end else if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
            state_reg   <= GAP;
            trig_reg    <= 1'b0;
            err_reg     <= 1'b1;
            gap_cnt_reg <= '0;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            flag_reg  <= 4'b0000;
            src_reg   <= SRC_NONE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.flag = flag_reg;
  assign bus.trig = trig_reg;
  assign bus.busy = busy_reg;
  assign bus.err  = err_reg;

endmodule

// File: tb/tb_gsm_cmd_sequencer.sv
// Bench for gsm_cmd_sequencer: a timing/arithmetic reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
`timescale 1ns/1ps
module tb_gsm_cmd_sequencer;
  localparam int GAP_CYCLES = 3;
  localparam int TIMEOUT    = 16;
  localparam int PEND_MAX   = 15;
  localparam int LAST_STAGE = 3;

  logic clk_1mhz = 1'b0;
  logic rst;
  gsm_cmd_sequencer_if bus();

  gsm_cmd_sequencer #(
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT), .PEND_W(4), .LAST_STAGE(LAST_STAGE)
  ) dut (
    .clk_1mhz(clk_1mhz),
    .rst     (rst),
    .bus     (bus)
  );

  always #500 clk_1mhz = ~clk_1mhz;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (handshake as time windows) ----------------
  int       cyc = 0;
  bit       m_valid = 0;
  bit       m_in_hs = 0;
  int       m_issue_start = 0;
  int       m_gap_end = 0;
  bit [3:0] m_cmd = 0;
  int       m_src = 0;          // 0 none, 1 hit, 2 miss, 3 pause
  int       m_hit = 0, m_miss = 0;
  bit       m_pause = 0, m_err = 0;
  bit       m_trig = 0, m_busy = 0;
  bit [3:0] m_flag = 0;

  always @(posedge clk_1mhz) begin
    int p; bit consumed; bit [3:0] f; int s; bit run;
    p = cyc;
    cyc = cyc + 1;
    consumed = 1'b0;
    f = 4'b0000;
    s = 0;
    run = (bus.gs_timer_running === 1'b1);
    if (rst === 1'b1) begin
      m_valid = 1; m_in_hs = 0; m_gap_end = cyc; m_err = 0;
      m_hit = 0; m_miss = 0; m_pause = 0; m_cmd = 0; m_src = 0;
    end else begin
      if (m_in_hs) begin
        if (bus.gs_done === 1'b1) begin
          consumed = 1'b1; m_in_hs = 0; m_gap_end = cyc + GAP_CYCLES;
        end else if (p - m_issue_start + 1 >= TIMEOUT) begin
          m_err = 1; m_in_hs = 0; m_gap_end = cyc + GAP_CYCLES;
        end
      end else if (p >= m_gap_end) begin
        case (bus.gs_state)
          3'b001: if (bus.gs_timer == 0) f = 4'b1010; else if (!run) f = 4'b0101;
          3'b010: begin
            if (bus.gs_lives == 0) f = 4'b1101;
            else if (bus.gs_timer == 0) f = (bus.gs_stage == LAST_STAGE) ? 4'b1110 : 4'b1100;
            else if (m_pause) begin f = run ? 4'b0100 : 4'b0101; s = 3; end
            else if (m_miss > 0) begin f = 4'b0010; s = 2; end
            else if (m_hit > 0) begin f = 4'b0001; s = 1; end
          end
          3'b100: if (bus.start_btn) f = 4'b1000;
          3'b011, 3'b101: if (bus.start_btn) f = 4'b1111;
          default: ;
        endcase
        if (f != 4'b0000) begin
          m_in_hs = 1; m_issue_start = cyc; m_cmd = f; m_src = s;
        end
      end
      if (bus.gs_state != 3'b010) begin
        m_hit = 0; m_miss = 0; m_pause = 0;
      end else begin
        m_hit  = m_hit  + ((bus.hit_pulse  && run) ? 1 : 0) - ((consumed && m_src == 1) ? 1 : 0);
        m_miss = m_miss + ((bus.miss_pulse && run) ? 1 : 0) - ((consumed && m_src == 2) ? 1 : 0);
        if (m_hit > PEND_MAX) m_hit = PEND_MAX;
        if (m_hit < 0) m_hit = 0;
        if (m_miss > PEND_MAX) m_miss = PEND_MAX;
        if (m_miss < 0) m_miss = 0;
        if (bus.pause_btn) m_pause = 1;
        else if (consumed && m_src == 3) m_pause = 0;
      end
    end
    m_trig = m_in_hs;
    m_busy = m_in_hs || (cyc < m_gap_end);
    m_flag = m_busy ? m_cmd : 4'b0000;
  end

  always @(negedge clk_1mhz) begin
    if (m_valid) begin
      check("trig", bus.trig, m_trig);
      check("flag", bus.flag, m_flag);
      check("busy", bus.busy, m_busy);
      check("err",  bus.err,  m_err);
    end
  end

  // ---------------- manager responder: done after a latency ----------------
  int done_mode = 2;   // >=0 fixed latency, -1 never, -2 random per handshake
  int hs_age = 0, hs_lat = 0;
  bit hs_given = 0;
  int done_count [16];

  always @(negedge clk_1mhz) begin
    bus.gs_done = 1'b0;
    if (bus.trig !== 1'b1) begin
      hs_age = 0; hs_given = 0;
    end else begin
      if (hs_age == 0) hs_lat = (done_mode == -2) ? int'($urandom_range(0, 20)) : done_mode;
      if (!hs_given && hs_lat >= 0 && hs_age >= hs_lat) begin
        bus.gs_done = 1'b1;
        hs_given = 1;
        done_count[bus.flag] = done_count[bus.flag] + 1;
      end
      hs_age++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_1mhz);
  endtask

  task automatic set_gs(input logic [2:0] st, input logic [1:0] stg, input logic [1:0] lv,
                        input logic [6:0] tm, input logic run);
    bus.gs_state = st; bus.gs_stage = stg; bus.gs_lives = lv;
    bus.gs_timer = tm; bus.gs_timer_running = run;
  endtask

  task automatic wait_trig(input logic level, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.trig === level) begin ok = 1; break; end
      tick(1);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timed out, trig=%0b want %0b", name, bus.trig, level);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.busy === 1'b0) begin ok = 1; break; end
      tick(1);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timed out, busy=%0b want 0", name, bus.busy);
    end
  endtask

  task automatic wait_cmd(input string name, input logic [3:0] exp_flag);
    wait_trig(1'b1, name);
    check(name, bus.flag, exp_flag);
    wait_trig(1'b0, name);
  endtask

  task automatic count_rises(input int n, output int rises, output int min_gap);
    bit prev, seen; int low_run;
    prev = 0; seen = 0; low_run = 0; rises = 0; min_gap = 999;
    for (int i = 0; i < n; i++) begin
      if (bus.trig === 1'b1 && !prev) begin
        rises++;
        if (seen && low_run < min_gap) min_gap = low_run;
      end
      if (bus.trig === 1'b1) begin seen = 1; low_run = 0; end
      else low_run++;
      prev = (bus.trig === 1'b1);
      bus.hit_pulse = (i < 5) && (n < 0);
      tick(1);
    end
  endtask

  // ---------------- directed scenarios then random soak ----------------
  initial begin
    int rises, gap, base, hi;
    rst = 1'b1;
    bus.hit_pulse = 0; bus.miss_pulse = 0; bus.start_btn = 0; bus.pause_btn = 0;
    bus.gs_done = 0;
    set_gs(3'b000, 2'd0, 2'd3, 7'd0, 1'b0);
    tick(3);
    check("reset_trig", bus.trig, 1'b0);
    check("reset_flag", bus.flag, 4'b0000);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_err",  bus.err,  1'b0);
    rst = 1'b0;
    tick(6);
    check("state000_idle", bus.busy, 1'b0);

    // Ready: countdown start, then timer reaches zero
    done_mode = 2;
    set_gs(3'b001, 2'd0, 2'd3, 7'd4, 1'b0);
    wait_cmd("ready_countdown", 4'b0101);
    set_gs(3'b001, 2'd0, 2'd3, 7'd0, 1'b1);
    wait_cmd("ready_to_play", 4'b1010);
    set_gs(3'b010, 2'd1, 2'd3, 7'd60, 1'b1);
    wait_idle("play_settle");

    // Five consecutive hits -> five 0001 handshakes separated by 4 low cycles
    base = done_count[1];
    rises = 0; gap = 999;
    begin
      bit prev, seen; int low_run;
      prev = 0; seen = 0; low_run = 0;
      for (int i = 0; i < 150; i++) begin
        if (bus.trig === 1'b1 && !prev) begin
          rises++;
          if (seen && low_run < gap) gap = low_run;
        end
        if (bus.trig === 1'b1) begin seen = 1; low_run = 0; end
        else low_run++;
        prev = (bus.trig === 1'b1);
        bus.hit_pulse = (i < 5);
        tick(1);
      end
    end
    check("hits_rises", rises, 5);
    check("hits_done", done_count[1] - base, 5);
    check("hits_min_gap", gap, GAP_CYCLES + 1);

    // Simultaneous hit and miss: miss first, then hit; then lives=0 wins
    bus.hit_pulse = 1; bus.miss_pulse = 1;
    tick(1);
    bus.hit_pulse = 0; bus.miss_pulse = 0;
    wait_cmd("miss_first", 4'b0010);
    wait_cmd("hit_second", 4'b0001);
    bus.gs_lives = 2'd0; bus.hit_pulse = 1;
    tick(2);
    bus.hit_pulse = 0;
    wait_cmd("game_over", 4'b1101);
    set_gs(3'b011, 2'd1, 2'd0, 7'd60, 1'b0);
    tick(3);
    set_gs(3'b010, 2'd1, 2'd3, 7'd60, 1'b1);
    count_rises(30, rises, gap);
    check("flushed_no_cmd", rises, 0);

    // Timer expiry in last and non-last stage, then continue/restart presses
    set_gs(3'b010, 2'd3, 2'd3, 7'd0, 1'b1);
    wait_cmd("game_clear", 4'b1110);
    set_gs(3'b101, 2'd3, 2'd3, 7'd0, 1'b0);
    tick(2);
    set_gs(3'b010, 2'd2, 2'd3, 7'd0, 1'b1);
    wait_cmd("stage_clear", 4'b1100);
    set_gs(3'b100, 2'd2, 2'd3, 7'd0, 1'b0);
    wait_idle("sclear_idle");
    bus.start_btn = 1; tick(1); bus.start_btn = 0;
    wait_cmd("to_ready", 4'b1000);
    set_gs(3'b011, 2'd2, 2'd0, 7'd0, 1'b0);
    wait_idle("over_idle");
    bus.start_btn = 1; tick(1); bus.start_btn = 0;
    wait_cmd("restart", 4'b1111);
    set_gs(3'b010, 2'd1, 2'd3, 7'd60, 1'b1);
    wait_idle("replay_idle");

    // Manager never answers: timeout, sticky err, retry of the same command
    done_mode = -1;
    bus.hit_pulse = 1; tick(1); bus.hit_pulse = 0;
    wait_trig(1'b1, "to_rise");
    hi = 0;
    while (bus.trig === 1'b1 && hi < 40) begin hi++; tick(1); end
    check("timeout_len", hi, TIMEOUT);
    check("timeout_err", bus.err, 1'b1);
    wait_trig(1'b1, "retry_rise");
    check("retry_flag", bus.flag, 4'b0001);
    done_mode = 2;
    tick(60);
    wait_idle("retry_idle");
    check("err_sticky", bus.err, 1'b1);

    // 20 hits during a stalled handshake -> saturate at 15 commands
    done_mode = -1;
    tick(1);
    base = done_count[1];
    bus.hit_pulse = 1; tick(20); bus.hit_pulse = 0;
    done_mode = 1;
    tick(300);
    check("sat_count", done_count[1] - base, PEND_MAX);

    // Reset in the middle of ISSUE
    done_mode = -1;
    bus.hit_pulse = 1; tick(1); bus.hit_pulse = 0;
    wait_trig(1'b1, "rst_rise");
    tick(3);
    rst = 1; tick(1); rst = 0;
    check("rst_mid_trig", bus.trig, 1'b0);
    check("rst_mid_flag", bus.flag, 4'b0000);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_err",  bus.err,  1'b0);

    // Random soak
    done_mode = -2;
    for (int i = 0; i < 4000; i++) begin
      if (i % 50 == 0) begin
        logic [2:0] st;
        case ($urandom_range(0, 9))
          0: st = 3'b000; 1: st = 3'b001; 2: st = 3'b011;
          3: st = 3'b100; 4: st = 3'b101; default: st = 3'b010;
        endcase
        set_gs(st, 2'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3)),
               ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 99)),
               ($urandom_range(0, 3) != 0));
      end
      bus.hit_pulse  = ($urandom_range(0, 3) == 0);
      bus.miss_pulse = ($urandom_range(0, 5) == 0);
      bus.pause_btn  = ($urandom_range(0, 19) == 0);
      bus.start_btn  = ($urandom_range(0, 14) == 0);
      rst            = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 0;
    bus.hit_pulse = 0; bus.miss_pulse = 0; bus.pause_btn = 0; bus.start_btn = 0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
